ifu_fetch: RTL

- Multi-cycle instruction fetch unit that sits directly upstream of the decode/execute core.
- Owns the architectural fetch PC and issues word reads on a valid/ready memory request channel.
- Accepts responses of variable latency and presents each instruction with its PC to the core over a valid/ready handshake.
- Accepts redirects (jal/jalr/branch targets) from the core and discards stale fetches.

---
 rtl/ifu_fetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues one word read at a time and
// hands each instruction (with its PC and fault flag) to the core over valid/ready.
module ifu_fetch #(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            reset,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_req_addr,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   input  logic            mem_rsp_err,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_err,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            halt
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_nxt;
   logic            discard;
   logic            discard_nxt;
   logic [XLEN-1:0] inst_nxt;
   logic [XLEN-1:0] inst_pc_nxt;
   logic            inst_err_nxt;
   logic [XLEN-1:0] redirect_target;

   assign redirect_target = redirect_pc & ~XLEN'(3);
   assign mem_req_addr    = pc;

   // Request is gated by reset too, since the state register already sits in S_REQ during reset.
   assign mem_req_valid   = (state == S_REQ) & ~halt & ~redirect_valid & ~reset;
   assign inst_valid      = (state == S_HOLD);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_REQ;
         pc       <= RESET_PC;
         discard  <= 1'b0;
         inst     <= '0;
         inst_pc  <= RESET_PC;
         inst_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         discard  <= discard_nxt;
         inst     <= inst_nxt;
         inst_pc  <= inst_pc_nxt;
         inst_err <= inst_err_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      discard_nxt  = discard;
      inst_nxt     = inst;
      inst_pc_nxt  = inst_pc;
      inst_err_nxt = inst_err;

      if (redirect_valid) begin
         pc_nxt = redirect_target;
         // A response landing in the same cycle as the redirect is the stale one; drop it now.
         if ((state == S_WAIT) && !mem_rsp_valid) begin
            discard_nxt = 1'b1;
            state_nxt   = S_WAIT;
         end else begin
            discard_nxt = 1'b0;
            state_nxt   = S_REQ;
         end
      end else begin
         case (state)
            S_REQ: begin
               if (mem_req_valid && mem_req_ready) begin
                  state_nxt = S_WAIT;
               end
            end
            S_WAIT: begin
               if (mem_rsp_valid) begin
                  if (discard) begin
                     discard_nxt = 1'b0;
                     state_nxt   = S_REQ;
                  end else begin
                     inst_nxt     = mem_rsp_data;
                     inst_pc_nxt  = pc;
                     inst_err_nxt = mem_rsp_err;
                     state_nxt    = S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  if (inst_err) begin
                     state_nxt = S_FAULT;
                  end else begin
                     pc_nxt    = pc + XLEN'(4);
                     state_nxt = S_REQ;
                  end
               end
            end
            S_FAULT: begin
               state_nxt = S_FAULT;
            end
            default: begin
               state_nxt = S_REQ;
            end
         endcase
      end
   end

endmodule
